lsu_sequencer: RTL and testbench
================================

Name: lsu_sequencer

Overview:
Load/store sequencer between the core's decoded memory controls (mem_req/mem_we/mem_size from the instruction decoder, address from the ALU, store data from RS2) and a single-port data-memory bus with a ready handshake. Each access runs as a 3-state FSM. The block stalls the core until the access finishes. It generates byte enables and lane-replicated store data, and it aligns and sign- or zero-extends load data. A programmable timeout flags a bus error.

Parameters:
TIMEOUT, 255, max BUSY cycles waiting for mem_ready_i before abort; 0 = no timeout
CNT_W, 8, width of timeout counter; must hold TIMEOUT

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  reset, synchronous, active-low
core_req_i  input  1  memory instruction present (decoder mem_req)
core_we_i  input  1  1 = store, 0 = load
core_size_i  input  3  LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5
core_addr_i  input  32  byte address from ALU
core_wd_i  input  32  store data (RS2)
core_rd_o  output  32  aligned, extended load data
core_stall_o  output  1  hold PC and pipeline
bus_err_o  output  1  1-cycle pulse, access aborted by timeout
mem_req_o  output  1  bus request
mem_we_o  output  1  bus write
mem_be_o  output  4  byte enables
mem_addr_o  output  32  word address {addr[31:2],2'b00}
mem_wd_o  output  32  lane-replicated write data
mem_rd_i  input  32  bus read word
mem_ready_i  input  1  access complete; valid only while mem_req_o=1

Behaviour:
- Reset (rst_ni=0 at an edge): state=IDLE. All registered outputs clear: mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wd_o=0, core_rd_o=0, bus_err_o=0, timeout counter=0. A reset mid-access abandons the access; mem_req_o is 0 from the next cycle on.
- IDLE:
  - core_stall_o = core_req_i, combinational.
  - On core_req_i=1: latch we, size, addr, wd; counter=0; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - mem_req_o=1; mem_we_o, mem_be_o, mem_addr_o, mem_wd_o are driven from the latched values and held stable.
  - core_stall_o=1.
  - On mem_ready_i=1: for a load, register the formatted mem_rd_i into core_rd_o; go to DONE.
  - Else, if TIMEOUT!=0 and counter==TIMEOUT-1: go to DONE with bus_err_o=1 and core_rd_o=0.
  - Else counter+1.
- DONE:
  - core_stall_o=0; mem_req_o=0; core_rd_o holds.
  - core_req_i is ignored, because it is the same instruction and the core advances at this edge.
  - Always go to IDLE.
  - bus_err_o is high only in DONE after a timeout.
- Latency: a zero-wait bus gives 3 cycles per access (IDLE, BUSY, DONE). Each wait cycle adds 1.
- Byte enables:
  - B/BU: 4'b0001<<addr[1:0].
  - H/HU: addr[1] ? 4'b1100 : 4'b0011.
  - W: 4'b1111.
  - mem_be_o is driven for loads too.
- Store data:
  - B: {4{wd[7:0]}}.
  - H: {2{wd[15:0]}}.
  - W: wd.
- Load formatting:
  - B/BU: byte at lane addr[1:0], sign- or zero-extended to 32 bits.
  - H/HU: half at addr[1], sign- or zero-extended.
  - W: whole word.
- Undefined size codes (3, 6, 7) are treated as W.
- core_rd_o is unchanged by stores.
- Counter width: CNT_W bits, no wrap. Abort fires exactly at TIMEOUT cycles in BUSY.
- mem_ready_i outside BUSY is ignored.
- If mem_ready_i=1 arrives in the same cycle as the timeout, ready wins and no error is flagged.

Optional Feature:
LSU_MISALIGN_EN
- Defined: in IDLE, with core_req_i=1 and a misaligned address (H/HU with addr[0]=1, or W with addr[1:0]!=0):
  - No bus request is made; go IDLE->DONE directly.
  - Output misalign_o (1 bit, registered) is 1 in DONE; core_rd_o=0.
  - misalign_o reset value is 0.
- Undefined: the misalign_o port is absent. Low address bits beyond the lane selection are ignored (H uses addr[1] only, W ignores addr[1:0]), and the access proceeds normally.

Test Plan:
- Reset mid-BUSY, ready never asserted: rst_ni=0 for 1 edge -> next cycle mem_req_o=0, state IDLE, core_stall_o=0 with core_req_i=0.
- SW: addr=0x1002, wd=0xDEADBEEF, size=W, ready in first BUSY cycle -> mem_addr_o=0x1000, be=1111, wd=0xDEADBEEF, stall high 2 cycles then low.
- SB: addr=0x0003, wd=0x000000A5 -> be=1000, mem_wd_o=0xA5A5A5A5, mem_we_o=1.
- LB vs LBU: addr=0x0001, mem_rd_i=0x00008000 after 2 wait cycles -> stall high 4 cycles; LB core_rd_o=0xFFFFFF80, LBU=0x00000080.
- LH vs LHU: addr=0x0002, mem_rd_i=0x80010000 -> LH 0xFFFF8001, LHU 0x00008001.
- TIMEOUT=4, ready held 0 -> mem_req_o high exactly 4 cycles, then bus_err_o pulses 1 cycle, core_rd_o=0, stall drops. Repeat with ready on the 4th BUSY cycle -> no error.

Source files
------------

// File: rtl/lsu_sequencer_if.sv
// lsu_sequencer_if
//   Data-memory bus between the load/store sequencer and a single-port memory.
//   Signal suffixes are from the sequencer's point of view.
//
//   mem_req_o    1   bus request
//   mem_we_o     1   bus write
//   mem_be_o     4   byte enables
//   mem_addr_o   32  word address (low two bits zero)
//   mem_wd_o     32  lane-replicated write data
//   mem_rd_i     32  read word returned by memory
//   mem_ready_i  1   access complete, meaningful only while mem_req_o=1
//
//   master: the sequencer side; slave: the memory side.
interface lsu_sequencer_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  modport master (
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    input  mem_rd_i, mem_ready_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
    output mem_rd_i, mem_ready_i
  );
endinterface

// File: rtl/lsu_sequencer.sv
// lsu_sequencer
//   Sequences one core load/store onto a single-port data-memory bus as an
//   IDLE -> BUSY -> DONE walk, stalling the core meanwhile. Generates byte
//   enables and lane-replicated store data, aligns and sign/zero-extends load
//   data, and aborts with a one-cycle bus_err_o pulse after TIMEOUT BUSY cycles.
//
// Parameters
//   TIMEOUT  max BUSY cycles waiting for mem_ready_i (0 = wait forever)
//   CNT_W    width of the timeout counter, must hold TIMEOUT
//
// Ports
//   clk_i, rst_ni          clock (rising edge), synchronous active-low reset
//   core_req_i/we_i/size_i decoded memory controls (size: B=0 H=1 W=2 BU=4 HU=5)
//   core_addr_i/core_wd_i  byte address and store data
//   core_rd_o              aligned, extended load data
//   core_stall_o           hold PC and pipeline
//   bus_err_o              one-cycle pulse when an access times out
//   mem                    data-memory bus (lsu_sequencer_if.master)
//   misalign_o             only with LSU_MISALIGN_EN: misaligned access flag
//
// Configuration macro
//   LSU_MISALIGN_EN  when defined, misaligned H/HU/W accesses skip the bus and
//                    raise misalign_o in DONE; when undefined the surplus low
//                    address bits are ignored and the access proceeds.
module lsu_sequencer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        bus_err_o,
`ifdef LSU_MISALIGN_EN
  output logic        misalign_o,
`endif
  lsu_sequencer_if.master mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  // Codes 0/4 are byte, 1/5 half; everything else (2, 3, 6, 7) is a word.
  function automatic logic is_byte(input logic [2:0] s);
    return (s[1:0] == 2'd0) && (s != 3'd6 || 1'b1) && (s[1] == 1'b0) && (s == 3'd0 || s == 3'd4);
  endfunction

  function automatic logic is_half(input logic [2:0] s);
    return (s == 3'd1) || (s == 3'd5);
  endfunction

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  lo_q, lo_d;
  logic [31:0] rd_q, rd_d;
  logic        err_q, err_d;
  logic        misal_q, misal_d;

  logic [3:0]  be_calc;
  logic [31:0] wd_calc;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;
  logic        ld_sign;
  logic        misaligned;
  logic        timeout_hit;

  // Lane steering for the incoming request, evaluated while IDLE.
  always_comb begin
    be_calc = 4'b1111;
    wd_calc = core_wd_i;
    if (is_byte(core_size_i)) begin
      be_calc = 4'b0001 << core_addr_i[1:0];
      wd_calc = {4{core_wd_i[7:0]}};
    end else if (is_half(core_size_i)) begin
      be_calc = core_addr_i[1] ? 4'b1100 : 4'b0011;
      wd_calc = {2{core_wd_i[15:0]}};
    end
  end

  // Misaligned detection only matters when the feature is built in.
  always_comb begin
    misaligned = 1'b0;
`ifdef LSU_MISALIGN_EN
    if (is_half(core_size_i))
      misaligned = core_addr_i[0];
    else if (!is_byte(core_size_i))
      misaligned = (core_addr_i[1:0] != 2'b00);
`endif
  end

  // Load alignment uses the latched low address bits, since mem_addr_o is
  // word aligned.
  always_comb begin
    ld_sign = ~size_q[2];
    case (lo_q)
      2'd0:    ld_byte = mem.mem_rd_i[7:0];
      2'd1:    ld_byte = mem.mem_rd_i[15:8];
      2'd2:    ld_byte = mem.mem_rd_i[23:16];
      default: ld_byte = mem.mem_rd_i[31:24];
    endcase
    ld_half = lo_q[1] ? mem.mem_rd_i[31:16] : mem.mem_rd_i[15:0];
    if (is_byte(size_q))
      ld_fmt = {{24{ld_sign & ld_byte[7]}}, ld_byte};
    else if (is_half(size_q))
      ld_fmt = {{16{ld_sign & ld_half[15]}}, ld_half};
    else
      ld_fmt = mem.mem_rd_i;
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // Next-state and next-value logic for every registered output.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = 1'b0;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wd_d         = wd_q;
    size_d       = size_q;
    lo_d         = lo_q;
    rd_d         = rd_q;
    err_d        = 1'b0;
    misal_d      = 1'b0;
    core_stall_o = 1'b0;

    case (state_q)
      IDLE: begin
        core_stall_o = core_req_i;
        if (core_req_i) begin
          if (misaligned) begin
            state_d = DONE;
            misal_d = 1'b1;
            rd_d    = '0;
          end else begin
            state_d = BUSY;
            req_d   = 1'b1;
            cnt_d   = '0;
            we_d    = core_we_i;
            be_d    = be_calc;
            addr_d  = {core_addr_i[31:2], 2'b00};
            wd_d    = wd_calc;
            size_d  = core_size_i;
            lo_d    = core_addr_i[1:0];
          end
        end
      end
      BUSY: begin
        core_stall_o = 1'b1;
        if (mem.mem_ready_i) begin
          state_d = DONE;
          if (!we_q)
            rd_d = ld_fmt;
        end else if (timeout_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
          rd_d    = '0;
        end else begin
          req_d = 1'b1;
          if (cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      size_q  <= '0;
      lo_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      misal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      size_q  <= size_d;
      lo_q    <= lo_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      misal_q <= misal_d;
    end
  end

  assign mem.mem_req_o  = req_q;
  assign mem.mem_we_o   = we_q;
  assign mem.mem_be_o   = be_q;
  assign mem.mem_addr_o = addr_q;
  assign mem.mem_wd_o   = wd_q;
  assign core_rd_o      = rd_q;
  assign bus_err_o      = err_q;
`ifdef LSU_MISALIGN_EN
  assign misalign_o     = misal_q;
`else
  logic unused_misal;
  assign unused_misal   = misal_q;
`endif

endmodule

// File: tb/tb_lsu_sequencer.sv
// tb_lsu_sequencer
//   Directed plus randomized accesses against a behavioural model of the
//   sequencer's lane, extension and timeout rules. Built with TIMEOUT=4.
module tb_lsu_sequencer;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        bus_err_o;
`ifdef LSU_MISALIGN_EN
  logic        misalign_o;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_rd = '0;

  lsu_sequencer_if bus();

  lsu_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .bus_err_o    (bus_err_o),
`ifdef LSU_MISALIGN_EN
    .misalign_o   (misalign_o),
`endif
    .mem          (bus.master)
  );

  always #5 clk_i = ~clk_i;

  // 0 = byte, 1 = half, 2 = word
  function automatic int kind(input logic [2:0] s);
    if (s == 3'd0 || s == 3'd4) return 0;
    if (s == 3'd1 || s == 3'd5) return 1;
    return 2;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] s, input logic [31:0] a);
    int lane = int'(a % 4);
    case (kind(s))
      0:       return 4'(1 << lane);
      1:       return (lane >= 2) ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] s, input logic [31:0] wd);
    case (kind(s))
      0:       return (wd % 256) * 32'h0101_0101;
      1:       return (wd % 65536) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] s, input logic [31:0] a,
                                             input logic [31:0] rd);
    longint v;
    bit     sgn = (s == 3'd0 || s == 3'd1);
    case (kind(s))
      0: begin
        v = longint'((rd >> (8 * (a % 4))) % 256);
        if (sgn && v >= 128) v = v - 256;
      end
      1: begin
        v = longint'((rd >> (16 * ((a % 4) / 2))) % 65536);
        if (sgn && v >= 32768) v = v - 65536;
      end
      default: v = longint'(rd);
    endcase
    return 32'(v);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete access. wait_cycles < 0 means the memory never answers.
  task automatic applyStimulus(input logic we, input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] rd, input int wait_cycles);
    bit misal = 1'b0;
    bit to;
    int busy_n;
`ifdef LSU_MISALIGN_EN
    misal = (kind(size) == 1 && addr[0]) || (kind(size) == 2 && addr[1:0] != 2'b00);
`endif
    to     = !misal && (TIMEOUT != 0) && (wait_cycles < 0 || wait_cycles >= int'(TIMEOUT));
    busy_n = misal ? 0 : (to ? int'(TIMEOUT) : wait_cycles + 1);

    @(negedge clk_i);
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
    #1;
    checkOutput("idle_stall", 32'(core_stall_o), 32'd1);

    for (int c = 0; c < busy_n; c++) begin
      @(negedge clk_i);
      checkOutput("busy_req", 32'(bus.mem_req_o), 32'd1);
      checkOutput("busy_stall", 32'(core_stall_o), 32'd1);
      checkOutput("busy_we", 32'(bus.mem_we_o), 32'(we));
      checkOutput("busy_be", 32'(bus.mem_be_o), 32'(model_be(size, addr)));
      checkOutput("busy_addr", bus.mem_addr_o, addr - (addr % 4));
      if (we) checkOutput("busy_wd", bus.mem_wd_o, model_wd(size, wd));
      bus.mem_ready_i = (c == wait_cycles);
      bus.mem_rd_i    = (c == wait_cycles) ? rd : $urandom();
    end

    @(negedge clk_i);
    bus.mem_ready_i = 1'b0;
    bus.mem_rd_i    = $urandom();
    if (to || misal)
      exp_rd = '0;
    else if (!we)
      exp_rd = model_load(size, addr, rd);
    checkOutput("done_req", 32'(bus.mem_req_o), 32'd0);
    checkOutput("done_stall", 32'(core_stall_o), 32'd0);
    checkOutput("done_err", 32'(bus_err_o), 32'(to));
    checkOutput("done_rd", core_rd_o, exp_rd);
`ifdef LSU_MISALIGN_EN
    checkOutput("done_misalign", 32'(misalign_o), 32'(misal));
`endif
    core_req_i = 1'b0;

    @(negedge clk_i);
    checkOutput("idle_req", 32'(bus.mem_req_o), 32'd0);
    checkOutput("idle_err", 32'(bus_err_o), 32'd0);
    checkOutput("idle_stall0", 32'(core_stall_o), 32'd0);
    checkOutput("idle_rd", core_rd_o, exp_rd);
  endtask

  initial begin
    rst_ni          = 1'b0;
    core_req_i      = 1'b0;
    core_we_i       = 1'b0;
    core_size_i     = '0;
    core_addr_i     = '0;
    core_wd_i       = '0;
    bus.mem_rd_i    = '0;
    bus.mem_ready_i = 1'b0;
    $display("[TB] reset");
    repeat (2) @(negedge clk_i);
    checkOutput("rst_req", 32'(bus.mem_req_o), 32'd0);
    checkOutput("rst_we", 32'(bus.mem_we_o), 32'd0);
    checkOutput("rst_be", 32'(bus.mem_be_o), 32'd0);
    checkOutput("rst_addr", bus.mem_addr_o, 32'd0);
    checkOutput("rst_wd", bus.mem_wd_o, 32'd0);
    checkOutput("rst_rd", core_rd_o, 32'd0);
    checkOutput("rst_err", 32'(bus_err_o), 32'd0);
    rst_ni = 1'b1;

    $display("[TB] directed accesses");
    applyStimulus(1'b1, 3'd2, 32'h0000_1002, 32'hDEAD_BEEF, 32'h0, 0);
    applyStimulus(1'b1, 3'd0, 32'h0000_0003, 32'h0000_00A5, 32'h0, 1);
    applyStimulus(1'b0, 3'd0, 32'h0000_0001, 32'h0, 32'h0000_8000, 2);
    checkOutput("lb_value", core_rd_o, 32'hFFFF_FF80);
    applyStimulus(1'b0, 3'd4, 32'h0000_0001, 32'h0, 32'h0000_8000, 2);
    checkOutput("lbu_value", core_rd_o, 32'h0000_0080);
    applyStimulus(1'b0, 3'd1, 32'h0000_0002, 32'h0, 32'h8001_0000, 0);
    checkOutput("lh_value", core_rd_o, 32'hFFFF_8001);
    applyStimulus(1'b0, 3'd5, 32'h0000_0002, 32'h0, 32'h8001_0000, 0);
    checkOutput("lhu_value", core_rd_o, 32'h0000_8001);
    applyStimulus(1'b1, 3'd1, 32'h0000_0010, 32'h1234_5678, 32'h0, 0);
    checkOutput("store_keeps_rd", core_rd_o, 32'h0000_8001);

    $display("[TB] timeout boundaries");
    applyStimulus(1'b0, 3'd2, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, -1);
    checkOutput("timeout_rd", core_rd_o, 32'h0);
    applyStimulus(1'b0, 3'd2, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, int'(TIMEOUT) - 1);
    checkOutput("ready_wins", core_rd_o, 32'hCAFE_F00D);
    applyStimulus(1'b0, 3'd6, 32'h0000_0104, 32'h0, 32'h0BAD_CAFE, 0);

    $display("[TB] reset mid-access");
    @(negedge clk_i);
    core_req_i  = 1'b1;
    core_we_i   = 1'b0;
    core_size_i = 3'd2;
    core_addr_i = 32'h0000_0200;
    repeat (2) @(negedge clk_i);
    checkOutput("pre_rst_req", 32'(bus.mem_req_o), 32'd1);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni     = 1'b1;
    core_req_i = 1'b0;
    exp_rd     = '0;
    #1;
    checkOutput("mid_rst_req", 32'(bus.mem_req_o), 32'd0);
    checkOutput("mid_rst_stall", 32'(core_stall_o), 32'd0);
    checkOutput("mid_rst_rd", core_rd_o, 32'd0);
    @(negedge clk_i);
    checkOutput("post_rst_req", 32'(bus.mem_req_o), 32'd0);

    $display("[TB] random accesses");
    for (int n = 0; n < 300; n++) begin
      int w = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(),
                    $urandom(), $urandom(), w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
